// File: rtl/ariane_clint_lite.sv
// Core-local interruptor: prescaled 64-bit mtime, per-hart mtimecmp/msip over AXI4-Lite.
// One write and one read outstanding; responses are registered and hold until accepted.
module ariane_clint_lite #(
  parameter int unsigned NR_HARTS       = 1,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned RTC_DIV        = 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [NR_HARTS-1:0]           timer_irq_o,
  output logic [NR_HARTS-1:0]           ipi_o
);

  localparam int unsigned NB = AXI_DATA_WIDTH / 8;
  localparam int unsigned PW = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic       hit;
    logic       is_msip;
    logic       is_cmp;
    logic       is_mtime;
    logic [3:0] hart;
    logic [2:0] bsel;
  } dec_t;

  // Maps one byte address onto the register byte that lives there, if any.
  function automatic dec_t decode(input logic [15:0] a);
    dec_t d;
    d      = '0;
    d.bsel = a[2:0];
    for (int h = 0; h < NR_HARTS; h++) begin
      if (a[15:2] == 14'(h)) begin
        d.hit     = 1'b1;
        d.is_msip = 1'b1;
        d.hart    = 4'(h);
      end
      if (a[15:3] == 13'(32'h800 + h)) begin
        d.hit    = 1'b1;
        d.is_cmp = 1'b1;
        d.hart   = 4'(h);
      end
    end
    if (a[15:3] == 13'h17FF) begin
      d.hit      = 1'b1;
      d.is_mtime = 1'b1;
    end
    return d;
  endfunction

  logic [PW-1:0]              presc_q, presc_d;
  logic [63:0]                mtime_q, mtime_d;
  logic [NR_HARTS-1:0][63:0]  mtimecmp_q, mtimecmp_d;
  logic [NR_HARTS-1:0]        msip_q, msip_d;
  logic [NR_HARTS-1:0]        timer_irq_q, timer_irq_d;
  logic                       bvalid_q, bvalid_d;
  logic [1:0]                 bresp_q, bresp_d;
  logic                       rvalid_q, rvalid_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;

  logic                       tick;
  logic                       wr_hs, rd_hs;
  logic [15:0]                wr_base, rd_base;
  logic                       wr_hit, rd_hit;
  dec_t                       wr_dec, rd_dec;
  logic [7:0]                 wr_byte;
  logic [AXI_DATA_WIDTH-1:0]  rd_data;

  assign tick    = (presc_q == PW'(RTC_DIV - 1));
  assign wr_hs   = s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
  assign rd_hs   = s_axil_arvalid & ~rvalid_q;
  assign wr_base = s_axil_awaddr[15:0] & ~16'(NB - 1);
  assign rd_base = s_axil_araddr[15:0] & ~16'(NB - 1);

  // Default mtime_d already carries the tick, so unwritten bytes of a
  // same-cycle mtime write pick up mtime+1.
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    mtime_d    = mtime_q + 64'(tick);
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    wr_hit     = 1'b0;
    wr_dec     = '0;
    wr_byte    = '0;
    for (int i = 0; i < NB; i++) begin
      wr_dec  = decode(wr_base | 16'(i));
      wr_byte = s_axil_wdata[8*i +: 8];
      wr_hit  = wr_hit | wr_dec.hit;
      if (wr_hs && s_axil_wstrb[i]) begin
        if (wr_dec.is_mtime) begin
          mtime_d[{wr_dec.bsel, 3'b000} +: 8] = wr_byte;
        end
        for (int h = 0; h < NR_HARTS; h++) begin
          if (wr_dec.is_cmp && wr_dec.hart == 4'(h)) begin
            mtimecmp_d[h][{wr_dec.bsel, 3'b000} +: 8] = wr_byte;
          end
          if (wr_dec.is_msip && wr_dec.hart == 4'(h) && wr_dec.bsel[1:0] == 2'b00) begin
            msip_d[h] = wr_byte[0];
          end
        end
      end
    end
  end

  always_comb begin
    rd_hit  = 1'b0;
    rd_dec  = '0;
    rd_data = '0;
    for (int i = 0; i < NB; i++) begin
      rd_dec = decode(rd_base | 16'(i));
      rd_hit = rd_hit | rd_dec.hit;
      if (rd_dec.is_mtime) begin
        rd_data[8*i +: 8] = mtime_q[{rd_dec.bsel, 3'b000} +: 8];
      end
      for (int h = 0; h < NR_HARTS; h++) begin
        if (rd_dec.is_cmp && rd_dec.hart == 4'(h)) begin
          rd_data[8*i +: 8] = mtimecmp_q[h][{rd_dec.bsel, 3'b000} +: 8];
        end
        if (rd_dec.is_msip && rd_dec.hart == 4'(h) && rd_dec.bsel[1:0] == 2'b00) begin
          rd_data[8*i +: 8] = {7'b0, msip_q[h]};
        end
      end
    end
  end

  always_comb begin
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
    if (wr_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_hit ? RESP_OKAY : RESP_DECERR;
    end
    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (rd_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_DECERR;
      rdata_d  = rd_hit ? rd_data : '0;
    end
    for (int h = 0; h < NR_HARTS; h++) begin
      timer_irq_d[h] = (mtime_q >= mtimecmp_q[h]);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      presc_q     <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= '0;
      timer_irq_q <= '0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign s_axil_awready = wr_hs;
  assign s_axil_wready  = wr_hs;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = ~rvalid_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rdata   = rdata_q;
  assign timer_irq_o    = timer_irq_q;
  assign ipi_o          = msip_q;

endmodule

// File: tb/tb_ariane_clint_lite.sv
// Bench: 64-bit/2-hart/RTC_DIV=4 instance against a cycle-count model, plus a 32-bit/1-hart instance with literal vectors.
module tb_ariane_clint_lite;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic aresetn;

  logic [15:0] a_awaddr, a_araddr;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic [63:0] a_wdata, a_rdata;
  logic [7:0]  a_wstrb;
  logic [1:0]  a_bresp, a_rresp, a_irq, a_ipi;

  logic [15:0] b_awaddr, b_araddr;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rvalid, b_rready;
  logic [31:0] b_wdata, b_rdata;
  logic [3:0]  b_wstrb;
  logic [1:0]  b_bresp, b_rresp;
  logic [0:0]  b_irq, b_ipi;

  ariane_clint_lite #(.NR_HARTS(2), .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(16), .RTC_DIV(DIV)) u_a (
    .aclk(clk), .aresetn(aresetn),
    .s_axil_awaddr(a_awaddr), .s_axil_awvalid(a_awvalid), .s_axil_awready(a_awready),
    .s_axil_wdata(a_wdata), .s_axil_wstrb(a_wstrb), .s_axil_wvalid(a_wvalid), .s_axil_wready(a_wready),
    .s_axil_bresp(a_bresp), .s_axil_bvalid(a_bvalid), .s_axil_bready(a_bready),
    .s_axil_araddr(a_araddr), .s_axil_arvalid(a_arvalid), .s_axil_arready(a_arready),
    .s_axil_rdata(a_rdata), .s_axil_rresp(a_rresp), .s_axil_rvalid(a_rvalid), .s_axil_rready(a_rready),
    .timer_irq_o(a_irq), .ipi_o(a_ipi));

  ariane_clint_lite #(.NR_HARTS(1), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .RTC_DIV(1)) u_b (
    .aclk(clk), .aresetn(aresetn),
    .s_axil_awaddr(b_awaddr), .s_axil_awvalid(b_awvalid), .s_axil_awready(b_awready),
    .s_axil_wdata(b_wdata), .s_axil_wstrb(b_wstrb), .s_axil_wvalid(b_wvalid), .s_axil_wready(b_wready),
    .s_axil_bresp(b_bresp), .s_axil_bvalid(b_bvalid), .s_axil_bready(b_bready),
    .s_axil_araddr(b_araddr), .s_axil_arvalid(b_arvalid), .s_axil_arready(b_arready),
    .s_axil_rdata(b_rdata), .s_axil_rresp(b_rresp), .s_axil_rvalid(b_rvalid), .s_axil_rready(b_rready),
    .timer_irq_o(b_irq), .ipi_o(b_ipi));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Model: mtime as written base plus ticks elapsed since the write edge.
  int          edge_n;
  logic [63:0] m_mt_base;
  int          m_mt_edge;
  logic [63:0] m_cmp [2];
  logic [1:0]  m_msip;

  always @(posedge clk or negedge aresetn)
    if (!aresetn) edge_n <= 0;
    else          edge_n <= edge_n + 1;

  function automatic logic [63:0] mtime_at(input int n);
    return m_mt_base + 64'((n + 1) / DIV - (m_mt_edge + 1) / DIV);
  endfunction

  function automatic void model_reset();
    m_mt_base = '0;
    m_mt_edge = -1;
    m_cmp[0]  = '1;
    m_cmp[1]  = '1;
    m_msip    = '0;
  endfunction

  function automatic void exp_read(input logic [15:0] addr, input int n,
                                   output logic [63:0] d, output logic [1:0] resp);
    int a;
    logic [63:0] v;
    bit mapped;
    mapped = 0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      a = int'(addr & 16'hFFF8) + i;
      if (a < 8) begin
        mapped = 1;
        if (a % 4 == 0) d[8*i] = m_msip[a/4];
      end else if (a >= 32'h4000 && a < 32'h4010) begin
        mapped = 1;
        v = m_cmp[(a - 32'h4000) / 8];
        d[8*i +: 8] = 8'(v >> (8 * (a % 8)));
      end else if (a >= 32'hBFF8 && a <= 32'hBFFF) begin
        mapped = 1;
        v = mtime_at(n);
        d[8*i +: 8] = 8'(v >> (8 * (a % 8)));
      end
    end
    resp = mapped ? 2'b00 : 2'b11;
  endfunction

  function automatic void model_write(input logic [15:0] addr, input logic [63:0] data,
                                      input logic [7:0] strb, input int w);
    int a;
    logic [63:0] nv;
    bit touched;
    nv = mtime_at(w);
    touched = 0;
    for (int i = 0; i < 8; i++) begin
      a = int'(addr & 16'hFFF8) + i;
      if (strb[i]) begin
        if (a < 8) begin
          if (a % 4 == 0) m_msip[a/4] = data[8*i];
        end else if (a >= 32'h4000 && a < 32'h4010) begin
          m_cmp[(a - 32'h4000) / 8][8*(a%8) +: 8] = data[8*i +: 8];
        end else if (a >= 32'hBFF8 && a <= 32'hBFFF) begin
          nv[8*(a%8) +: 8] = data[8*i +: 8];
          touched = 1;
        end
      end
    end
    if (touched) begin
      m_mt_base = nv;
      m_mt_edge = w;
    end
  endfunction

  // Per-cycle compare of the interrupt lines of instance A.
  logic [1:0] pend_irq;
  bit         cmp_en = 0;
  always @(negedge clk) begin
    if (!aresetn) begin
      pend_irq = '0;
      if (cmp_en) begin
        chk("rst_irq", 64'(a_irq), 64'd0);
        chk("rst_ipi", 64'(a_ipi), 64'd0);
      end
    end else begin
      if (cmp_en) begin
        chk("cyc_irq", 64'(a_irq), 64'(pend_irq));
        chk("cyc_ipi", 64'(a_ipi), 64'(m_msip));
      end
      for (int h = 0; h < 2; h++) pend_irq[h] = (mtime_at(edge_n - 1) >= m_cmp[h]);
    end
  end

  task automatic wr64(input logic [15:0] addr, input logic [63:0] data, input logic [7:0] strb,
                      output logic [1:0] resp);
    logic [63:0] dd;
    logic [1:0] er;
    bit ok;
    @(negedge clk); #1;
    a_awaddr = addr; a_wdata = data; a_wstrb = strb; a_awvalid = 1; a_wvalid = 1;
    #1; ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_awready) begin ok = 1; break; end
      @(negedge clk); #2;
    end
    resp = 2'bxx;
    if (!ok) begin
      chk("wr64_timeout", 64'd0, 64'd1);
      a_awvalid = 0; a_wvalid = 0;
    end else begin
      exp_read(addr, edge_n - 1, dd, er);
      model_write(addr, data, strb, edge_n);
      @(posedge clk); #1;
      a_awvalid = 0; a_wvalid = 0;
      @(negedge clk);
      chk("wr64_bvalid", 64'(a_bvalid), 64'd1);
      chk("wr64_bresp", 64'(a_bresp), 64'(er));
      resp = a_bresp;
    end
  endtask

  task automatic rd64(input logic [15:0] addr, output logic [63:0] data, output logic [1:0] resp);
    logic [63:0] ed;
    logic [1:0] er;
    bit ok;
    @(negedge clk); #1;
    a_araddr = addr; a_arvalid = 1;
    #1; ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_arready) begin ok = 1; break; end
      @(negedge clk); #2;
    end
    data = 'x; resp = 2'bxx;
    if (!ok) begin
      chk("rd64_timeout", 64'd0, 64'd1);
      a_arvalid = 0;
    end else begin
      exp_read(addr, edge_n - 1, ed, er);
      @(posedge clk); #1;
      a_arvalid = 0;
      @(negedge clk);
      chk("rd64_rvalid", 64'(a_rvalid), 64'd1);
      chk("rd64_rdata", a_rdata, ed);
      chk("rd64_rresp", 64'(a_rresp), 64'(er));
      data = a_rdata; resp = a_rresp;
    end
  endtask

  task automatic wr32(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input logic [1:0] exp_resp);
    bit ok;
    @(negedge clk); #1;
    b_awaddr = addr; b_wdata = data; b_wstrb = strb; b_awvalid = 1; b_wvalid = 1;
    #1; ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (b_awready) begin ok = 1; break; end
      @(negedge clk); #2;
    end
    if (!ok) chk("wr32_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk); #1;
      b_awvalid = 0; b_wvalid = 0;
      @(negedge clk);
      chk("wr32_bvalid", 64'(b_bvalid), 64'd1);
      chk("wr32_bresp", 64'(b_bresp), 64'(exp_resp));
    end
    b_awvalid = 0; b_wvalid = 0;
  endtask

  task automatic rd32(input logic [15:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit ok;
    @(negedge clk); #1;
    b_araddr = addr; b_arvalid = 1;
    #1; ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (b_arready) begin ok = 1; break; end
      @(negedge clk); #2;
    end
    if (!ok) chk("rd32_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk); #1;
      b_arvalid = 0;
      @(negedge clk);
      chk("rd32_rvalid", 64'(b_rvalid), 64'd1);
      chk("rd32_rdata", 64'(b_rdata), 64'(exp_data));
      chk("rd32_rresp", 64'(b_rresp), 64'(exp_resp));
    end
    b_arvalid = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d, ed, m;
    logic [1:0]  r, er;
    bit found;

    aresetn = 0;
    a_awaddr = 0; a_awvalid = 0; a_wdata = 0; a_wstrb = 0; a_wvalid = 0; a_bready = 1;
    a_araddr = 0; a_arvalid = 0; a_rready = 1;
    b_awaddr = 0; b_awvalid = 0; b_wdata = 0; b_wstrb = 0; b_wvalid = 0; b_bready = 1;
    b_araddr = 0; b_arvalid = 0; b_rready = 1;
    model_reset();
    cmp_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_bvalid", 64'(a_bvalid), 0);
    chk("rst_rvalid", 64'(a_rvalid), 0);
    chk("rst_bresp", 64'(a_bresp), 0);
    chk("rst_rresp", 64'(a_rresp), 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_b_out", {b_rdata, 26'd0, b_rvalid, b_bvalid, b_irq, b_ipi, 2'(b_rresp | b_bresp)}, 0);
    #1 aresetn = 1;

    // Reset contents and boundaries of the map.
    rd64(16'h4000, d, r);
    chk("lit_cmp0_rst", d, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lit_cmp0_okay", 64'(r), 64'd0);
    rd64(16'h4008, d, r);
    rd64(16'hBFF8, d, r);
    chk("lit_mtime_small", 64'(d < 64'd16), 64'd1);
    rd64(16'h8000, d, r);
    chk("lit_unmapped_rdata", d, 64'd0);
    chk("lit_unmapped_rresp", 64'(r), 64'd3);
    rd64(16'h4010, d, r);
    rd64(16'h0008, d, r);
    wr64(16'h8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, r);
    chk("lit_unmapped_bresp", 64'(r), 64'd3);
    rd64(16'h4000, d, r);

    // Software interrupts.
    wr64(16'h0000, 64'hFFFF_FFFF, 8'h0F, r);
    rd64(16'h0000, d, r);
    chk("lit_msip0_read", d, 64'h1);
    wr64(16'h0004, 64'h1_0000_0000, 8'hF0, r);
    rd64(16'h0000, d, r);
    chk("lit_msip_both", d, 64'h0000_0001_0000_0001);
    chk("lit_ipi_both", 64'(a_ipi), 64'd3);
    wr64(16'h0000, 64'd0, 8'hFF, r);

    // mtime write, prescaling, partial writes near ticks, wrap.
    wr64(16'hBFF8, 64'h10, 8'hFF, r);
    repeat (8) @(negedge clk);
    rd64(16'hBFF8, d, r);
    chk("lit_mtime_div", 64'(d >= 64'h11 && d <= 64'h13), 64'd1);
    for (int k = 0; k < 4; k++) begin
      wr64(16'hBFF8, 64'h0, 8'hFE, r);
      rd64(16'hBFF8, d, r);
    end
    wr64(16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    repeat (6) @(negedge clk);
    rd64(16'hBFF8, d, r);
    chk("lit_mtime_wrap", 64'(d < 64'd4), 64'd1);
    wr64(16'hBFF8, 64'h20, 8'hFF, r);

    // Timer compares.
    wr64(16'h4000, 64'h8000_0000_0000_0000, 8'hFF, r);
    @(negedge clk);
    m = mtime_at(edge_n - 1);
    wr64(16'h4008, m + 64'd5, 8'hFF, r);
    found = 0;
    for (int k = 0; k < 5 * DIV + 8; k++) begin
      @(negedge clk);
      if (a_irq == 2'b10) begin found = 1; break; end
    end
    chk("irq1_rises", 64'(found), 64'd1);
    wr64(16'h4008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, r);
    chk("lit_irq1_held", 64'(a_irq), 64'd2);
    @(negedge clk);
    chk("lit_irq1_cleared", 64'(a_irq), 64'd0);
    wr64(16'h4000, 64'd0, 8'hFF, r);
    repeat (2) @(negedge clk);
    chk("lit_irq0_set", 64'(a_irq), 64'd1);

    // Same-cycle read and write of one register: the read sees the old value.
    @(negedge clk); #1;
    a_awaddr = 16'h4000; a_wdata = 64'h1234; a_wstrb = 8'hFF; a_awvalid = 1; a_wvalid = 1;
    a_araddr = 16'h4000; a_arvalid = 1;
    #1;
    chk("both_ready", 64'({a_awready, a_arready}), 64'd3);
    exp_read(16'h4000, edge_n - 1, ed, er);
    model_write(16'h4000, 64'h1234, 8'hFF, edge_n);
    @(posedge clk); #1;
    a_awvalid = 0; a_wvalid = 0; a_arvalid = 0;
    @(negedge clk);
    chk("rw_old_rdata", a_rdata, ed);
    chk("lit_rw_old", a_rdata, 64'd0);
    rd64(16'h4000, d, r);

    // Write response backpressure, then reset while the response is pending.
    a_bready = 0;
    @(negedge clk); #1;
    a_awaddr = 16'h0000; a_wdata = 64'h1; a_wstrb = 8'h0F; a_awvalid = 1; a_wvalid = 1;
    #1;
    chk("bp_first_ready", 64'(a_awready), 64'd1);
    model_write(16'h0000, 64'h1, 8'h0F, edge_n);
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_bvalid", 64'(a_bvalid), 64'd1);
      chk("bp_bresp", 64'(a_bresp), 64'd0);
      chk("bp_awready", 64'(a_awready), 64'd0);
    end
    #1 aresetn = 0;
    model_reset();
    #1;
    chk("bp_reset_bvalid", 64'(a_bvalid), 64'd0);
    a_awvalid = 0; a_wvalid = 0; a_bready = 1;
    @(negedge clk); #1 aresetn = 1;
    rd64(16'h0000, d, r);

    // 32-bit bus instance.
    rd32(16'h4000, 32'hFFFF_FFFF, 2'b00);
    wr32(16'h4004, 32'h1, 4'hF, 2'b00);
    rd32(16'h4004, 32'h1, 2'b00);
    rd32(16'h4000, 32'hFFFF_FFFF, 2'b00);
    wr32(16'h4000, 32'h1234_5678, 4'b0011, 2'b00);
    rd32(16'h4000, 32'hFFFF_5678, 2'b00);
    wr32(16'h0000, 32'hFFFF_FFFF, 4'hF, 2'b00);
    rd32(16'h0000, 32'h1, 2'b00);
    chk("b_ipi", 64'(b_ipi), 64'd1);
    rd32(16'h0004, 32'h0, 2'b11);
    rd32(16'h8000, 32'h0, 2'b11);
    wr32(16'h8000, 32'hFFFF_FFFF, 4'hF, 2'b11);
    rd32(16'hBFFC, 32'h0, 2'b00);
    wr32(16'h4004, 32'h0, 4'hF, 2'b00);
    chk("b_irq_low", 64'(b_irq), 64'd0);
    wr32(16'h4000, 32'h0, 4'hF, 2'b00);
    chk("b_irq_one_cycle", 64'(b_irq), 64'd0);
    @(negedge clk);
    chk("b_irq_two_cycles", 64'(b_irq), 64'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ariane_clint_lite.md
# ariane_clint_lite

Parametrised core-local interruptor for the Ariane FPGA peripheral subsystem: one `mtime` counter with a configurable prescaler, `NR_HARTS` `mtimecmp` compare registers, and `NR_HARTS` `msip` software-interrupt bits. All registers are exposed through a single AXI4-Lite slave port with a 32- or 64-bit data path. The block drives per-hart timer and IPI interrupt lines into the core complex. It replaces the fixed single-hart timer path previously fed through the peripheral wrapper.

## Interface
- `NR_HARTS`, 1: number of harts; legal range 1..16.
- `AXI_DATA_WIDTH`, 64: AXI-Lite data width; 32 or 64 only.
- `AXI_ADDR_WIDTH`, 16: address width; only bits [15:0] are decoded and upper bits are ignored.
- `RTC_DIV`, 1: `aclk` cycles per `mtime` increment; at least 1.
- `aclk` in 1: the only clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axil_aw{addr,valid,ready}`: in/in/out, AXI_ADDR_WIDTH/1/1. Write address channel.
- `s_axil_w{data,strb,valid,ready}`: in/in/in/out, AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1. Write data channel.
- `s_axil_b{resp,valid,ready}`: out/out/in, 2/1/1. Write response channel.
- `s_axil_ar{addr,valid,ready}`: in/in/out, AXI_ADDR_WIDTH/1/1. Read address channel.
- `s_axil_r{data,resp,valid,ready}`: out/out/out/in, AXI_DATA_WIDTH/2/1/1. Read data channel.
- `timer_irq_o` out NR_HARTS: per-hart machine timer interrupt.
- `ipi_o` out NR_HARTS: per-hart machine software interrupt.

## Operation
- Register map, byte addresses:
  - `msip[h]` at 0x0000+4h, 32 bits; only bit 0 is implemented, other bits read 0.
  - `mtimecmp[h]` at 0x4000+8h, 64 bits.
  - `mtime` at 0xBFF8, 64 bits.
- Beat addressing: a beat covers bytes (A & ~(AXI_DATA_WIDTH/8-1)) onward for AXI_DATA_WIDTH/8 bytes. Each register byte sits on its natural lane.
- With a 32-bit bus, A[2] selects the low or high half of 64-bit registers.
- Writes update only bytes whose `wstrb` bit is set. Reads return unmapped bytes inside a mapped beat as 0.
- A beat containing no mapped byte returns DECERR (2'b11): writes have no effect and reads return data 0. Mapped beats return OKAY (2'b00).
- Prescaler: a counter runs 0..RTC_DIV-1 and a tick occurs when it equals RTC_DIV-1, after which it wraps to 0. `mtime` increments by 1 on each tick and wraps from 2^64-1 to 0.
- `mtime` write in the same cycle as a tick: written bytes take `wdata`; unwritten bytes take the bytes of `mtime`+1. The prescaler is not reset by the write.
- `timer_irq_o[h]` is registered and equals (`mtime` >= `mtimecmp[h]`), evaluated on the values held after the previous edge. The comparison is unsigned 64-bit.
- `ipi_o[h]` equals `msip[h][0]` and is driven directly from the register.
- Reset values:
  - `mtime`=0 and prescaler=0.
  - `mtimecmp[*]`=all ones.
  - `msip[*]`=0.
  - `timer_irq_o`=0 and `ipi_o`=0.
  - `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0.
- Assertion of `aresetn` mid-transaction drops any pending `bvalid`/`rvalid` immediately; the in-flight transaction is lost.

## Timing
- Write handshake:
  - `awready` = `wready` = `awvalid` & `wvalid` & !`bvalid`.
  - AW and W are accepted together in one cycle and never separately.
  - The register update occurs at that edge.
  - `bvalid` rises on the next cycle and holds with a stable `bresp` until `bready`.
- Read handshake:
  - `arready` = !`rvalid`.
  - `rdata`/`rresp` are captured at the acceptance edge from the current register state.
  - `rvalid` rises on the next cycle and holds stable until `rready`.
- One outstanding transaction per direction.
- Read and write channels are independent. On a same-cycle read and write to the same register, the read returns the old value.
- A write to `mtimecmp`/`mtime` affects `timer_irq_o` 2 cycles after the write handshake edge: one edge updates the register, the next registers the compare.
- A write to `msip` affects `ipi_o` 1 cycle after the handshake edge.
- `mtime` is visible via read 1 cycle after a tick.

## Test plan
- Reset then read, 64-bit bus: reading 0x4000 returns 0xFFFF_FFFF_FFFF_FFFF OKAY; reading 0xBFF8 returns a small count; all interrupt outputs are 0.
- RTC_DIV=4: write `mtime`=0x10 → a read 8 cycles later reflects 2 increments (±1 for read latency); the prescaler wraps correctly.
- NR_HARTS=2: write `mtimecmp[1]`=`mtime`+5 → `timer_irq_o`=2'b10 appears within 5·RTC_DIV+2 cycles; writing `mtimecmp[1]`=all ones clears it 2 cycles after the handshake.
- 32-bit bus: write 0x4004 with data 0x1 and strb 4'hF → the `mtimecmp[0]` high half is 1 and the low half is unchanged. Write `msip[0]` with 0xFFFF_FFFF → the read returns 0x1 and `ipi_o[0]`=1.
- Unmapped access: reading 0x8000 → DECERR with data 0; writing 0x8000 → DECERR with no register change.
- Backpressure: hold `bready`=0 for 10 cycles → `bvalid` and `bresp` stay stable and `awready` stays 0 throughout. Apply `aresetn` low mid-hold → `bvalid`=0 immediately.
